// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: ROM port, redirect request and decode handshake.
`timescale 1ns/1ps
interface inst_fetch_if;
  logic [31:0] rom_data_i;
  logic [31:0] rom_addr_o;
  logic        rom_ce_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        id_ready_i;
  logic        misalign_o;

  modport master (
    input  rom_data_i, redirect_i, redirect_pc_i, id_ready_i,
    output rom_addr_o, rom_ce_o, inst_valid_o, inst_o, inst_pc_o, misalign_o
  );

  modport slave (
    output rom_data_i, redirect_i, redirect_pc_i, id_ready_i,
    input  rom_addr_o, rom_ce_o, inst_valid_o, inst_o, inst_pc_o, misalign_o
  );
endinterface

// File: rtl/inst_fetch.sv
// PC + ROM fetch into a DEPTH-entry prefetch FIFO; IFETCH_MISALIGN_CHK_EN halts on misaligned redirects.
// Redirect-to-valid 1 cycle; decode backpressure fills the FIFO, then the PC holds.
`timescale 1ns/1ps
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst,
  inst_fetch_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [31:0]     r_pc;
  logic            r_ce;
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;
  logic            w_vld;
  logic            w_halt;
  logic [31:0]     w_redir_pc;

`ifdef IFETCH_MISALIGN_CHK_EN
  logic r_misalign;

  // A misaligned target is loaded verbatim and fetch stays halted until an aligned redirect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_misalign <= 1'b0;
    end else if (bus.redirect_i) begin
      r_misalign <= |bus.redirect_pc_i[1:0];
    end
  end

  assign w_halt         = r_misalign;
  assign w_redir_pc     = bus.redirect_pc_i;
  assign bus.misalign_o = r_misalign;
`else
  logic w_unused_lsbs;

  assign w_unused_lsbs  = ^bus.redirect_pc_i[1:0];
  assign w_halt         = 1'b0;
  assign w_redir_pc     = {bus.redirect_pc_i[31:2], 2'b00};
  assign bus.misalign_o = 1'b0;
`endif

  assign w_vld  = (r_count != '0);
  // Full is judged on the pre-pop count, so a full FIFO never pushes and pops together.
  assign w_push = r_ce & (r_count < FULL) & ~bus.redirect_i & ~w_halt;
  assign w_pop  = w_vld & bus.id_ready_i & ~bus.redirect_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc    <= RESET_PC;
      r_ce    <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_ce <= 1'b1;
      if (bus.redirect_i) begin
        r_pc    <= w_redir_pc;
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + PW'(1);
          r_pc   <= r_pc + 32'd4;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + PW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      r_mem[r_wptr] <= '{pc: r_pc, inst: bus.rom_data_i};
    end
  end

  assign bus.rom_addr_o   = r_pc;
  assign bus.rom_ce_o     = r_ce;
  assign bus.inst_valid_o = w_vld;
  assign bus.inst_o       = w_vld ? r_mem[r_rptr].inst : 32'h0;
  assign bus.inst_pc_o    = w_vld ? r_mem[r_rptr].pc   : 32'h0;
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: per-cycle vector table on a RESET_PC=0 instance, wrap stream on a RESET_PC=FFFF_FFF8 instance.
`timescale 1ns/1ps
module tb_inst_fetch;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic sb_en;

  inst_fetch_if b0 ();
  inst_fetch_if b1 ();

  // ROM word n holds n; reads 0 while disabled.
  assign b0.rom_data_i = b0.rom_ce_o ? {2'b00, b0.rom_addr_o[31:2]} : 32'h0;
  assign b1.rom_data_i = b1.rom_ce_o ? {2'b00, b1.rom_addr_o[31:2]} : 32'h0;

  inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u0 (.clk(clk), .rst(rst), .bus(b0));
  inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u1 (.clk(clk), .rst(rst), .bus(b1));

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        ce;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ipc;
    logic [31:0] inst;
    logic        mis;
  } vec_t;

  vec_t        tbl [21];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] e0;
  logic [31:0] e1;

  function automatic vec_t mk(input logic rdy, input logic rd, input logic [31:0] rpc,
                              input logic ce, input logic [31:0] addr, input logic vld,
                              input logic [31:0] ipc, input logic mis);
    vec_t v;
    v.rdy   = rdy;
    v.redir = rd;
    v.rpc   = rpc;
    v.ce    = ce;
    v.addr  = addr;
    v.vld   = vld;
    v.ipc   = vld ? ipc : 32'h0;
    v.inst  = vld ? (ipc >> 2) : 32'h0;
    v.mis   = mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboards: every accepted head must match the oldest expected transfer.
  always @(negedge clk) begin
    #2;
    if (rst && sb_en && b0.inst_valid_o && b0.id_ready_i && !b0.redirect_i) begin
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb0_unexpected: consumed pc %h with nothing expected", b0.inst_pc_o);
      end else begin
        e0 = q0.pop_front();
        chk("sb0_pc", b0.inst_pc_o, e0);
        chk("sb0_inst", b0.inst_o, e0 >> 2);
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst && b1.inst_valid_o && b1.id_ready_i && q1.size() != 0) begin
      e1 = q1.pop_front();
      chk("sb1_pc", b1.inst_pc_o, e1);
      chk("sb1_inst", b1.inst_o, e1 >> 2);
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    sb_en    = 1'b0;
    rst      = 1'b0;
    b0.redirect_i    = 1'b0;
    b0.redirect_pc_i = 32'h0;
    b0.id_ready_i    = 1'b0;
    b1.redirect_i    = 1'b0;
    b1.redirect_pc_i = 32'h0;
    b1.id_ready_i    = 1'b0;

    //        rdy  rd   rpc    ce   addr   vld  ipc    mis
    tbl[0]  = mk(0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0);
    tbl[1]  = mk(0, 0, 32'h0,  1, 32'h0,  0, 32'h0,  0);
    tbl[2]  = mk(0, 0, 32'h0,  1, 32'h4,  1, 32'h0,  0);
    tbl[3]  = mk(0, 0, 32'h0,  1, 32'h8,  1, 32'h0,  0);
    tbl[4]  = mk(1, 0, 32'h0,  1, 32'h8,  1, 32'h0,  0);
    tbl[5]  = mk(1, 0, 32'h0,  1, 32'h8,  1, 32'h4,  0);
    tbl[6]  = mk(1, 0, 32'h0,  1, 32'hC,  1, 32'h8,  0);
    tbl[7]  = mk(0, 0, 32'h0,  1, 32'h10, 1, 32'hC,  0);
    tbl[8]  = mk(0, 1, 32'h40, 1, 32'h14, 1, 32'hC,  0);
    tbl[9]  = mk(0, 0, 32'h0,  1, 32'h40, 0, 32'h0,  0);
    tbl[10] = mk(1, 1, 32'h80, 1, 32'h44, 1, 32'h40, 0);
    tbl[11] = mk(1, 0, 32'h0,  1, 32'h80, 0, 32'h0,  0);
    tbl[12] = mk(1, 0, 32'h0,  1, 32'h84, 1, 32'h80, 0);
    tbl[13] = mk(1, 1, 32'h42, 1, 32'h88, 1, 32'h84, 0);
`ifdef IFETCH_MISALIGN_CHK_EN
    tbl[14] = mk(1, 0, 32'h0,  1, 32'h42, 0, 32'h0,  1);
    tbl[15] = mk(1, 0, 32'h0,  1, 32'h42, 0, 32'h0,  1);
    tbl[16] = mk(1, 0, 32'h0,  1, 32'h42, 0, 32'h0,  1);
    tbl[17] = mk(1, 0, 32'h0,  1, 32'h42, 0, 32'h0,  1);
    tbl[18] = mk(1, 1, 32'h80, 1, 32'h42, 0, 32'h0,  1);
`else
    tbl[14] = mk(1, 0, 32'h0,  1, 32'h40, 0, 32'h0,  0);
    tbl[15] = mk(1, 0, 32'h0,  1, 32'h44, 1, 32'h40, 0);
    tbl[16] = mk(1, 0, 32'h0,  1, 32'h48, 1, 32'h44, 0);
    tbl[17] = mk(1, 0, 32'h0,  1, 32'h4C, 1, 32'h48, 0);
    tbl[18] = mk(1, 1, 32'h80, 1, 32'h50, 1, 32'h4C, 0);
`endif
    tbl[19] = mk(1, 0, 32'h0,  1, 32'h80, 0, 32'h0,  0);
    tbl[20] = mk(1, 0, 32'h0,  1, 32'h84, 1, 32'h80, 0);

    q1.push_back(32'hFFFF_FFF8);
    q1.push_back(32'hFFFF_FFFC);
    q1.push_back(32'h0000_0000);
    q1.push_back(32'h0000_0004);

    repeat (19) @(negedge clk);
    chk("rst_addr0", b0.rom_addr_o, 32'h0);
    chk("rst_ce0", {31'h0, b0.rom_ce_o}, 32'h0);
    chk("rst_vld0", {31'h0, b0.inst_valid_o}, 32'h0);
    chk("rst_inst0", b0.inst_o, 32'h0);
    chk("rst_ipc0", b0.inst_pc_o, 32'h0);
    chk("rst_mis0", {31'h0, b0.misalign_o}, 32'h0);
    chk("rst_addr1", b1.rom_addr_o, 32'hFFFF_FFF8);

    sb_en = 1'b1;
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      if (k == 0) begin
        rst = 1'b1;
        b1.id_ready_i = 1'b1;
      end
      chk($sformatf("v%0d_ce", k), {31'h0, b0.rom_ce_o}, {31'h0, tbl[k].ce});
      chk($sformatf("v%0d_addr", k), b0.rom_addr_o, tbl[k].addr);
      chk($sformatf("v%0d_vld", k), {31'h0, b0.inst_valid_o}, {31'h0, tbl[k].vld});
      chk($sformatf("v%0d_ipc", k), b0.inst_pc_o, tbl[k].ipc);
      chk($sformatf("v%0d_inst", k), b0.inst_o, tbl[k].inst);
      chk($sformatf("v%0d_mis", k), {31'h0, b0.misalign_o}, {31'h0, tbl[k].mis});
      b0.id_ready_i    = tbl[k].rdy;
      b0.redirect_i    = tbl[k].redir;
      b0.redirect_pc_i = tbl[k].rpc;
      if (tbl[k].rdy && !tbl[k].redir && tbl[k].vld) q0.push_back(tbl[k].ipc);
    end

    // Reset while the FIFO holds data must drop everything.
    @(negedge clk);
    sb_en = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    chk("rstmid_vld", {31'h0, b0.inst_valid_o}, 32'h0);
    chk("rstmid_ipc", b0.inst_pc_o, 32'h0);
    chk("rstmid_addr", b0.rom_addr_o, 32'h0);
    chk("rstmid_ce", {31'h0, b0.rom_ce_o}, 32'h0);
    chk("sb0_left", q0.size(), 32'h0);
    chk("sb1_left", q1.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage directly upstream of the instruction ROM. Holds the program counter, drives `rom_addr_o`/`rom_ce_o`, and captures `rom_data_i` with its PC into a small prefetch FIFO. Presents fetched instructions to decode over a valid/ready handshake. Accepts branch/jump redirects that flush in-flight instructions.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `DEPTH`, 2, prefetch FIFO entries (power of two, ≥2).
- `clk` in 1: system clock.
- `rst` in 1: synchronous active-low reset; `RstEnable` = 0, `RstDisable` = 1.
- `rom_data_i` in 32: instruction from ROM; combinational on `rom_addr_o`; 0 when `rom_ce_o`=0.
- `rom_addr_o` out 32: fetch address, byte address.
- `rom_ce_o` out 1: ROM chip enable.
- `redirect_i` in 1: flush and load new PC.
- `redirect_pc_i` in 32: redirect target.
- `inst_valid_o` out 1: FIFO head valid.
- `inst_o` out 32: head instruction.
- `inst_pc_o` out 32: head PC.
- `id_ready_i` in 1: decode accepts head.
- `misalign_o` out 1: misaligned redirect flag (see Configuration).

## Operation
- Registers: `pc`, `ce_q`, FIFO storage of {pc, inst}, read/write pointers, count (0..DEPTH).
- `rom_addr_o` = `pc`. `rom_ce_o` = `ce_q`. Both registered; no combinational path from any input.
- push = `rom_ce_o` & (count < DEPTH) & ~`redirect_i` & ~halted. Stores {`pc`, `rom_data_i`} at write pointer; `pc` <= `pc` + 4 (32-bit, wraps 32'hFFFF_FFFC -> 0).
- pop = `inst_valid_o` & `id_ready_i` & ~`redirect_i`.
- `inst_valid_o` = count != 0; `inst_o`/`inst_pc_o` = head entry; both 0 when empty.
- Full: count tested before pop; no push when count = DEPTH even if popping that cycle. Simultaneous push and pop at count < DEPTH: count unchanged, both pointers advance.
- Redirect (highest priority): count <= 0, pointers <= 0, `pc` <= target, no push or pop that cycle. Head visible in that cycle is discarded.
- `ce_q` <= 1 on every non-reset edge; 0 only during reset.
- Reset (`rst`=0 at posedge): `pc`=RESET_PC, `ce_q`=0, FIFO empty, `misalign_o`=0. Reset mid-fetch drops all FIFO contents; reset overrides `redirect_i`.

## Timing
- Reset values: `rom_addr_o`=RESET_PC, `rom_ce_o`=0, `inst_valid_o`=0, `inst_o`=0, `inst_pc_o`=0, `misalign_o`=0.
- Edge E0 is the first edge with `rst`=1: `rom_ce_o`=1 after E0. First push at E1; `inst_valid_o`=1 after E1.
- Redirect sampled at edge R: `rom_addr_o`=target after R. Target pushed at R+1 if no further redirect; valid after R+1. Redirect-to-valid latency is 1 cycle.
- With `id_ready_i` held 1, throughput is 1 instruction/cycle; FIFO stays at count 1.
- With `id_ready_i` held 0, FIFO fills after DEPTH pushes. `pc` then holds at (last pushed + 4), with `rom_ce_o` still 1.

## Configuration
- `IFETCH_MISALIGN_CHK_EN` defined:
  - On redirect with `redirect_pc_i[1:0]` != 0: `pc` <= full target, `misalign_o` <= 1, fetch halted (no pushes).
  - `misalign_o` is sticky until a redirect with aligned target (clears it, resumes) or reset.
  - `rom_ce_o` stays 1 while halted.
- Undefined: `pc` <= {`redirect_pc_i`[31:2], 2'b00}; `misalign_o` tied 0; never halts.

## Test plan
- Reset 195 ns, then `id_ready_i`=1, ROM word n = n -> `rom_addr_o` 0,4,8,…; `inst_pc_o`=0 with `inst_o`=0 one cycle after first push; one instruction per cycle, PC step +4.
- `id_ready_i`=0 from start -> exactly 2 pushes (PC 0,4), `pc` holds 8, `inst_pc_o` stays 0. Raise ready -> heads 0,4,8 on consecutive cycles; no gap or duplicate.
- FIFO full, assert `redirect_i` with `redirect_pc_i`=32'h40 -> next cycle count 0, `rom_addr_o`=40; following cycle `inst_pc_o`=40, old entries never appear.
- Redirect and `id_ready_i`=1 in same cycle while valid -> head not counted as consumed; next valid PC is target.
- RESET_PC=32'hFFFF_FFF8 -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- With `IFETCH_MISALIGN_CHK_EN`, redirect to 32'h42 -> `misalign_o`=1, no pushes for 5 cycles; redirect to 32'h80 -> `misalign_o`=0, `inst_pc_o`=80 two cycles later. Without the macro, the same stimulus -> fetch at 32'h40, `misalign_o`=0.
